// File: rtl/multicycle_pkg.sv
// Shared types and encodings for the multicycle RV32I control unit:
// FSM state enum, opcode constants, datapath select encodings and opcode classification.
package multicycle_pkg;

    typedef enum logic [2:0] {
        ST_IF   = 3'd0,
        ST_ID   = 3'd1,
        ST_EX   = 3'd2,
        ST_MEM  = 3'd3,
        ST_WB   = 3'd4,
        ST_HALT = 3'd5
    } state_e;

    localparam logic [6:0] OP_R_TYPE = 7'b0110011;
    localparam logic [6:0] OP_I_TYPE = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_ECALL  = 7'b1110011;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_FOUR = 2'b01;
    localparam logic [1:0] SRCB_IMM  = 2'b10;

    localparam logic [1:0] WB_ALUOUT = 2'b00;
    localparam logic [1:0] WB_MDR    = 2'b01;
    localparam logic [1:0] WB_ALU    = 2'b10;

    localparam logic PCSRC_ALU    = 1'b0;
    localparam logic PCSRC_ALUOUT = 1'b1;

    typedef enum logic [3:0] {
        CLS_R,
        CLS_I,
        CLS_LOAD,
        CLS_STORE,
        CLS_BRANCH,
        CLS_JAL,
        CLS_JALR,
        CLS_ECALL,
        CLS_UNKNOWN
    } op_class_e;

    function automatic op_class_e classify(input logic [6:0] opcode);
        op_class_e cls;
        case (opcode)
            OP_R_TYPE: cls = CLS_R;
            OP_I_TYPE: cls = CLS_I;
            OP_LOAD:   cls = CLS_LOAD;
            OP_STORE:  cls = CLS_STORE;
            OP_BRANCH: cls = CLS_BRANCH;
            OP_JAL:    cls = CLS_JAL;
            OP_JALR:   cls = CLS_JALR;
            OP_ECALL:  cls = CLS_ECALL;
            default:   cls = CLS_UNKNOWN;
        endcase
        return cls;
    endfunction

endpackage

// File: rtl/multicycle_next_state.sv
// Combinational next-state logic for the multicycle control FSM.
// MULTICYCLE_MEM_WAIT_EN: IF and MEM hold until mem_ready is high.
module multicycle_next_state
    import multicycle_pkg::*;
#(
    parameter int STATE_W = 3
) (
    input  logic [STATE_W-1:0] state,
    input  logic [6:0]         opcode,
    input  logic               alu_bcond,
    input  logic               ecall_halt,
    input  logic               mem_ready,
    output logic [STATE_W-1:0] next_state
);

    localparam logic [STATE_W-1:0] S_IF   = STATE_W'(ST_IF);
    localparam logic [STATE_W-1:0] S_ID   = STATE_W'(ST_ID);
    localparam logic [STATE_W-1:0] S_EX   = STATE_W'(ST_EX);
    localparam logic [STATE_W-1:0] S_MEM  = STATE_W'(ST_MEM);
    localparam logic [STATE_W-1:0] S_WB   = STATE_W'(ST_WB);
    localparam logic [STATE_W-1:0] S_HALT = STATE_W'(ST_HALT);

    op_class_e cls;
    logic      mem_go;

`ifdef MULTICYCLE_MEM_WAIT_EN
    assign mem_go = mem_ready;
`else
    assign mem_go = 1'b1;
    logic unused_mem_ready;
    assign unused_mem_ready = mem_ready;
`endif

    always_comb begin
        cls        = classify(opcode);
        next_state = S_IF;
        case (state)
            S_IF:   next_state = mem_go ? S_ID : S_IF;
            S_ID:   next_state = S_EX;
            S_EX: begin
                case (cls)
                    CLS_LOAD, CLS_STORE: next_state = S_MEM;
                    CLS_BRANCH:          next_state = alu_bcond ? S_IF : S_WB;
                    CLS_JAL:             next_state = S_IF;
                    CLS_ECALL:           next_state = ecall_halt ? S_HALT : S_WB;
                    default:             next_state = S_WB;
                endcase
            end
            S_MEM: begin
                if (!mem_go)
                    next_state = S_MEM;
                else if (cls == CLS_LOAD)
                    next_state = S_WB;
                else
                    next_state = S_IF;
            end
            S_WB:   next_state = S_IF;
            S_HALT: next_state = S_HALT;
            // Unreachable encodings recover to a fresh fetch
            default: next_state = S_IF;
        endcase
    end

endmodule

// File: rtl/multicycle_control_unit.sv
// Multicycle RV32I control unit: state register plus Moore output decode.
// MULTICYCLE_MEM_WAIT_EN: stall IF/MEM on mem_ready and gate ir_write with it.
module multicycle_control_unit
    import multicycle_pkg::*;
#(
    parameter int STATE_W = 3
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [6:0] opcode,
    input  logic       alu_bcond,
    input  logic       ecall_halt,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       pc_source,
    output logic       i_or_d,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic [1:0] mem_to_reg,
    output logic       reg_write,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] ALUOp,
    output logic       is_halted
);

    generate
        if (STATE_W < 3) begin : g_state_w_check
            $error("multicycle_control_unit: STATE_W must be at least 3");
        end
    endgenerate

    localparam logic [STATE_W-1:0] S_IF   = STATE_W'(ST_IF);
    localparam logic [STATE_W-1:0] S_ID   = STATE_W'(ST_ID);
    localparam logic [STATE_W-1:0] S_EX   = STATE_W'(ST_EX);
    localparam logic [STATE_W-1:0] S_MEM  = STATE_W'(ST_MEM);
    localparam logic [STATE_W-1:0] S_WB   = STATE_W'(ST_WB);
    localparam logic [STATE_W-1:0] S_HALT = STATE_W'(ST_HALT);

    logic [STATE_W-1:0] state;
    logic [STATE_W-1:0] next_state;
    op_class_e          cls;

    multicycle_next_state #(
        .STATE_W (STATE_W)
    ) u_next_state (
        .state      (state),
        .opcode     (opcode),
        .alu_bcond  (alu_bcond),
        .ecall_halt (ecall_halt),
        .mem_ready  (mem_ready),
        .next_state (next_state)
    );

    // Asynchronous reset drops straight to IF so in-flight strobes vanish immediately
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            state <= S_IF;
        else
            state <= next_state;
    end

    always_comb begin
        pc_write   = 1'b0;
        pc_source  = PCSRC_ALU;
        i_or_d     = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        ir_write   = 1'b0;
        mem_to_reg = WB_ALUOUT;
        reg_write  = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = SRCB_RS2;
        ALUOp      = ALUOP_ADD;
        is_halted  = 1'b0;
        cls        = classify(opcode);
        case (state)
            S_IF: begin
                mem_read = 1'b1;
                i_or_d   = 1'b0;
`ifdef MULTICYCLE_MEM_WAIT_EN
                ir_write = mem_ready;
`else
                ir_write = 1'b1;
`endif
            end
            S_ID: begin
                alu_src_a = 1'b0;
                alu_src_b = SRCB_IMM;
                ALUOp     = ALUOP_ADD;
            end
            S_EX: begin
                case (cls)
                    CLS_R: begin
                        alu_src_a = 1'b1;
                        alu_src_b = SRCB_RS2;
                        ALUOp     = ALUOP_FUNCT;
                    end
                    CLS_I: begin
                        alu_src_a = 1'b1;
                        alu_src_b = SRCB_IMM;
                        ALUOp     = ALUOP_FUNCT;
                    end
                    CLS_LOAD, CLS_STORE, CLS_JALR: begin
                        alu_src_a = 1'b1;
                        alu_src_b = SRCB_IMM;
                        ALUOp     = ALUOP_ADD;
                    end
                    CLS_BRANCH: begin
                        alu_src_a = 1'b1;
                        alu_src_b = SRCB_RS2;
                        ALUOp     = ALUOP_SUB;
                        if (alu_bcond) begin
                            pc_write  = 1'b1;
                            pc_source = PCSRC_ALUOUT;
                        end
                    end
                    CLS_JAL: begin
                        // ALU computes PC+4 for rd while ALUOut (PC+imm from ID) feeds the PC
                        alu_src_a  = 1'b0;
                        alu_src_b  = SRCB_FOUR;
                        ALUOp      = ALUOP_ADD;
                        reg_write  = 1'b1;
                        mem_to_reg = WB_ALU;
                        pc_write   = 1'b1;
                        pc_source  = PCSRC_ALUOUT;
                    end
                    default: ;
                endcase
            end
            S_MEM: begin
                i_or_d = 1'b1;
                if (cls == CLS_LOAD) begin
                    mem_read = 1'b1;
                end else if (cls == CLS_STORE) begin
                    mem_write = 1'b1;
                    alu_src_a = 1'b0;
                    alu_src_b = SRCB_FOUR;
                    ALUOp     = ALUOP_ADD;
                    pc_write  = 1'b1;
                    pc_source = PCSRC_ALU;
                end
            end
            S_WB: begin
                alu_src_a = 1'b0;
                alu_src_b = SRCB_FOUR;
                ALUOp     = ALUOP_ADD;
                pc_write  = 1'b1;
                pc_source = (cls == CLS_JALR) ? PCSRC_ALUOUT : PCSRC_ALU;
                case (cls)
                    CLS_R, CLS_I: begin
                        reg_write  = 1'b1;
                        mem_to_reg = WB_ALUOUT;
                    end
                    CLS_LOAD: begin
                        reg_write  = 1'b1;
                        mem_to_reg = WB_MDR;
                    end
                    CLS_JALR: begin
                        reg_write  = 1'b1;
                        mem_to_reg = WB_ALU;
                    end
                    default: ;
                endcase
            end
            S_HALT: is_halted = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Self-checking bench for multicycle_control_unit: per-cycle output vectors
// from an instruction table plus directed memory-wait, reset and halt sequences.
module tb_multicycle_control_unit;

    localparam logic [6:0] T_R      = 7'b0110011;
    localparam logic [6:0] T_I      = 7'b0010011;
    localparam logic [6:0] T_LOAD   = 7'b0000011;
    localparam logic [6:0] T_STORE  = 7'b0100011;
    localparam logic [6:0] T_BRANCH = 7'b1100011;
    localparam logic [6:0] T_JAL    = 7'b1101111;
    localparam logic [6:0] T_JALR   = 7'b1100111;
    localparam logic [6:0] T_ECALL  = 7'b1110011;
    localparam int         N_TBL    = 10;

    logic       clk;
    logic       reset_n;
    logic [6:0] opcode;
    logic       alu_bcond;
    logic       ecall_halt;
    logic       mem_ready;
    logic       pc_write;
    logic       pc_source;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic [1:0] mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic       is_halted;

    multicycle_control_unit dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .opcode     (opcode),
        .alu_bcond  (alu_bcond),
        .ecall_halt (ecall_halt),
        .mem_ready  (mem_ready),
        .pc_write   (pc_write),
        .pc_source  (pc_source),
        .i_or_d     (i_or_d),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .ir_write   (ir_write),
        .mem_to_reg (mem_to_reg),
        .reg_write  (reg_write),
        .alu_src_a  (alu_src_a),
        .alu_src_b  (alu_src_b),
        .ALUOp      (alu_op),
        .is_halted  (is_halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [6:0]       opcode;
        logic             bcond;
        logic             ehalt;
        logic [2:0]       n;
        logic [4:0][14:0] exp;
    } vec_t;

    vec_t        tbl [N_TBL];
    logic [14:0] exp_q [$];
    int          checks;
    int          passed;

    logic [14:0] V_IF, V_IF_WAIT, V_ID, EX_R, EX_I, EX_LS, EX_BT, EX_BN, EX_JAL, EX_JALR, EX_NOP;
    logic [14:0] MEM_LD, MEM_ST, WB_R, WB_LD, WB_JALR, WB_NOP, V_HALT;

    // Vector layout: pc_write pc_source i_or_d mem_read mem_write ir_write mem_to_reg reg_write alu_src_a alu_src_b ALUOp is_halted
    function automatic logic [14:0] ov(input logic pcw, input logic pcs, input logic iod,
                                       input logic mr, input logic mw, input logic irw,
                                       input logic [1:0] mtr, input logic rw, input logic asa,
                                       input logic [1:0] asb, input logic [1:0] aop, input logic h);
        return {pcw, pcs, iod, mr, mw, irw, mtr, rw, asa, asb, aop, h};
    endfunction

    function automatic logic [14:0] outs();
        return {pc_write, pc_source, i_or_d, mem_read, mem_write, ir_write,
                mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_op, is_halted};
    endfunction

    task automatic chk(input string name, input logic [14:0] act, input logic [14:0] exp);
        checks++;
        if (act === exp)
            passed++;
        else
            $display("FAIL %s: got %b expected %b", name, act, exp);
    endtask

    task automatic set_entry(input int idx, input logic [6:0] opc, input logic bc, input logic eh,
                             input int n, input logic [14:0] e0, input logic [14:0] e1,
                             input logic [14:0] e2, input logic [14:0] e3, input logic [14:0] e4);
        tbl[idx].opcode = opc;
        tbl[idx].bcond  = bc;
        tbl[idx].ehalt  = eh;
        tbl[idx].n      = 3'(n);
        tbl[idx].exp[0] = e0;
        tbl[idx].exp[1] = e1;
        tbl[idx].exp[2] = e2;
        tbl[idx].exp[3] = e3;
        tbl[idx].exp[4] = e4;
    endtask

    // Called 1 time unit after a rising edge: sample mid-cycle, pop one expectation, advance.
    task automatic cyc(input string name);
        logic [14:0] e;
        #3;
        if (exp_q.size() == 0) begin
            checks++;
            $display("FAIL %s: got empty scoreboard expected a queued vector", name);
        end else begin
            e = exp_q.pop_front();
            chk(name, outs(), e);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic step(input string name, input logic [14:0] e);
        exp_q.push_back(e);
        cyc(name);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        checks = 0;
        passed = 0;

        V_IF      = ov(0,0,0,1,0,1,2'b00,0,0,2'b00,2'b00,0);
        V_IF_WAIT = ov(0,0,0,1,0,0,2'b00,0,0,2'b00,2'b00,0);
        V_ID      = ov(0,0,0,0,0,0,2'b00,0,0,2'b10,2'b00,0);
        EX_R      = ov(0,0,0,0,0,0,2'b00,0,1,2'b00,2'b10,0);
        EX_I      = ov(0,0,0,0,0,0,2'b00,0,1,2'b10,2'b10,0);
        EX_LS     = ov(0,0,0,0,0,0,2'b00,0,1,2'b10,2'b00,0);
        EX_BT     = ov(1,1,0,0,0,0,2'b00,0,1,2'b00,2'b01,0);
        EX_BN     = ov(0,0,0,0,0,0,2'b00,0,1,2'b00,2'b01,0);
        EX_JAL    = ov(1,1,0,0,0,0,2'b10,1,0,2'b01,2'b00,0);
        EX_JALR   = ov(0,0,0,0,0,0,2'b00,0,1,2'b10,2'b00,0);
        EX_NOP    = 15'd0;
        MEM_LD    = ov(0,0,1,1,0,0,2'b00,0,0,2'b00,2'b00,0);
        MEM_ST    = ov(1,0,1,0,1,0,2'b00,0,0,2'b01,2'b00,0);
        WB_R      = ov(1,0,0,0,0,0,2'b00,1,0,2'b01,2'b00,0);
        WB_LD     = ov(1,0,0,0,0,0,2'b01,1,0,2'b01,2'b00,0);
        WB_JALR   = ov(1,1,0,0,0,0,2'b10,1,0,2'b01,2'b00,0);
        WB_NOP    = ov(1,0,0,0,0,0,2'b00,0,0,2'b01,2'b00,0);
        V_HALT    = ov(0,0,0,0,0,0,2'b00,0,0,2'b00,2'b00,1);

        set_entry(0, T_R,       0, 0, 4, V_IF, V_ID, EX_R,    WB_R,    15'd0);
        set_entry(1, T_I,       0, 0, 4, V_IF, V_ID, EX_I,    WB_R,    15'd0);
        set_entry(2, T_LOAD,    0, 0, 5, V_IF, V_ID, EX_LS,   MEM_LD,  WB_LD);
        set_entry(3, T_STORE,   0, 0, 4, V_IF, V_ID, EX_LS,   MEM_ST,  15'd0);
        set_entry(4, T_BRANCH,  1, 0, 3, V_IF, V_ID, EX_BT,   15'd0,   15'd0);
        set_entry(5, T_BRANCH,  0, 0, 4, V_IF, V_ID, EX_BN,   WB_NOP,  15'd0);
        set_entry(6, T_JAL,     0, 0, 3, V_IF, V_ID, EX_JAL,  15'd0,   15'd0);
        set_entry(7, T_JALR,    0, 0, 4, V_IF, V_ID, EX_JALR, WB_JALR, 15'd0);
        set_entry(8, T_ECALL,   0, 0, 4, V_IF, V_ID, EX_NOP,  WB_NOP,  15'd0);
        set_entry(9, 7'b0000000, 0, 0, 4, V_IF, V_ID, EX_NOP, WB_NOP,  15'd0);

        reset_n    = 1'b0;
        opcode     = T_STORE;
        alu_bcond  = 1'b0;
        ecall_halt = 1'b0;
        mem_ready  = 1'b1;
        #2;
        chk("reset_outputs", outs(), V_IF);
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("reset_held", outs(), V_IF);
        reset_n = 1'b1;

        // Table: the next entry's first vector (IF) also confirms each latency
        for (int i = 0; i < N_TBL; i++) begin
            opcode     = tbl[i].opcode;
            alu_bcond  = tbl[i].bcond;
            ecall_halt = tbl[i].ehalt;
            for (int k = 0; k < int'(tbl[i].n); k++)
                exp_q.push_back(tbl[i].exp[k]);
            for (int k = 0; k < int'(tbl[i].n); k++)
                cyc($sformatf("tbl%0d_op%b_c%0d", i, tbl[i].opcode, k));
        end
        alu_bcond = 1'b0;

        // Load with memory not ready
        opcode = T_LOAD;
`ifdef MULTICYCLE_MEM_WAIT_EN
        mem_ready = 1'b0;
        step("ldw_if_wait", V_IF_WAIT);
        mem_ready = 1'b1;
        step("ldw_if", V_IF);
        step("ldw_id", V_ID);
        step("ldw_ex", EX_LS);
        mem_ready = 1'b0;
        step("ldw_mem0", MEM_LD);
        step("ldw_mem1", MEM_LD);
        mem_ready = 1'b1;
        step("ldw_mem2", MEM_LD);
        step("ldw_wb", WB_LD);
`else
        mem_ready = 1'b0;
        step("ldn_if", V_IF);
        step("ldn_id", V_ID);
        step("ldn_ex", EX_LS);
        step("ldn_mem", MEM_LD);
        step("ldn_wb", WB_LD);
        mem_ready = 1'b1;
`endif
        step("ldw_next_if", V_IF);
        step("ldw_next_id", V_ID);
        step("ldw_next_ex", EX_LS);
        step("ldw_next_mem", MEM_LD);
        step("ldw_next_wb", WB_LD);

        // Reset asserted mid-cycle during a store MEM state
        opcode = T_STORE;
        step("st_if", V_IF);
        step("st_id", V_ID);
        step("st_ex", EX_LS);
        #3;
        chk("st_mem", outs(), MEM_ST);
        #1;
        reset_n = 1'b0;
        #1;
        chk("rst_async_mem_write", {14'd0, mem_write}, 15'd0);
        chk("rst_async_outputs", outs(), V_IF);
        @(posedge clk);
        #1;
        chk("rst_hold_outputs", outs(), V_IF);
        reset_n = 1'b1;
        opcode = T_R;
        step("post_rst_if", V_IF);
        step("post_rst_id", V_ID);
        step("post_rst_ex", EX_R);
        step("post_rst_wb", WB_R);

        // ECALL halt: absorbing regardless of inputs
        opcode     = T_ECALL;
        ecall_halt = 1'b1;
        step("ecall_if", V_IF);
        step("ecall_id", V_ID);
        step("ecall_ex", EX_NOP);
        opcode     = T_JAL;
        ecall_halt = 1'b0;
        for (int k = 0; k < 10; k++) begin
            mem_ready = k[0];
            alu_bcond = k[1];
            step($sformatf("halt_c%0d", k), V_HALT);
        end
        mem_ready = 1'b1;
        alu_bcond = 1'b0;
        reset_n   = 1'b0;
        #1;
        chk("halt_reset", outs(), V_IF);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        step("halt_recover_if", V_IF);
        step("halt_recover_id", V_ID);

        checks++;
        if (exp_q.size() == 0)
            passed++;
        else
            $display("FAIL scoreboard_drain: got %0d leftover expected 0", exp_q.size());

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
